// File: rtl/div_unit.sv
// ============================================================================
// Module   : div_unit
// Purpose  : Multi-cycle restoring divider (DIV/DIVU), one quotient bit per
//            clock. Optional divide-by-zero short-cut: DIV_BYZERO_EN.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic               annul_i,
    input  logic               signed_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o,
    output logic               busy_o
`ifdef DIV_BYZERO_EN
   ,output logic               byzero_o
`endif
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ON     = 2'd1,
        S_END    = 2'd2
`ifdef DIV_BYZERO_EN
       ,S_BYZERO = 2'd3
`endif
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_dvd;      // dividend bits shift out, quotient bits shift in
    logic [WIDTH-1:0]   r_dvs;
    logic [WIDTH-1:0]   r_rem;
    logic               r_neg_q;
    logic               r_neg_r;
    logic [2*WIDTH-1:0] r_result;
`ifdef DIV_BYZERO_EN
    logic               r_byzero;
`endif

    logic [WIDTH-1:0]   w_abs1;
    logic [WIDTH-1:0]   w_abs2;
    logic [WIDTH:0]     w_rem_sh;
    logic [WIDTH:0]     w_diff;
    logic               w_qbit;
    logic [WIDTH-1:0]   w_rem_nx;
    logic [WIDTH-1:0]   w_quo_nx;
    logic [WIDTH-1:0]   w_quo_fin;
    logic [WIDTH-1:0]   w_rem_fin;

    assign w_abs1 = (signed_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
    assign w_abs2 = (signed_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;

    // One restoring step: a borrow out of the trial subtraction means remainder < divisor
    assign w_rem_sh  = {r_rem, r_dvd[WIDTH-1]};
    assign w_diff    = w_rem_sh - {1'b0, r_dvs};
    assign w_qbit    = ~w_diff[WIDTH];
    assign w_rem_nx  = w_qbit ? w_diff[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
    assign w_quo_nx  = {r_dvd[WIDTH-2:0], w_qbit};
    assign w_quo_fin = r_neg_q ? -w_quo_nx : w_quo_nx;
    assign w_rem_fin = r_neg_r ? -w_rem_nx : w_rem_nx;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start_i) begin
`ifdef DIV_BYZERO_EN
                    w_next = (opdata2_i == '0) ? S_BYZERO : S_ON;
`else
                    w_next = S_ON;
`endif
                end
            end
            S_ON: begin
                if (!start_i) begin
                    w_next = S_IDLE;
                end else if (r_cnt == c_CNT_LAST) begin
                    w_next = S_END;
                end
            end
`ifdef DIV_BYZERO_EN
            S_BYZERO: begin
                w_next = start_i ? S_END : S_IDLE;
            end
`endif
            S_END: begin
                if (!start_i) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
        // Flush wins over everything, including a fresh request in IDLE
        if (annul_i) begin
            w_next = S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= '0;
            r_dvd    <= '0;
            r_dvs    <= '0;
            r_rem    <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_result <= '0;
`ifdef DIV_BYZERO_EN
            r_byzero <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_next == S_ON) begin
                        r_cnt    <= '0;
                        r_rem    <= '0;
                        r_dvd    <= w_abs1;
                        r_dvs    <= w_abs2;
                        r_neg_q  <= signed_i & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
                        r_neg_r  <= signed_i & opdata1_i[WIDTH-1];
`ifdef DIV_BYZERO_EN
                        r_byzero <= 1'b0;
`endif
                    end
`ifdef DIV_BYZERO_EN
                    if (w_next == S_BYZERO) begin
                        r_result <= '0;
                        r_byzero <= 1'b1;
                    end
`endif
                end
                S_ON: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    r_rem <= w_rem_nx;
                    r_dvd <= w_quo_nx;
                    if (w_next == S_END) begin
                        r_result <= {w_rem_fin, w_quo_fin};
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign ready_o  = (r_state == S_END);
    assign result_o = ready_o ? r_result : '0;
`ifdef DIV_BYZERO_EN
    assign busy_o   = (r_state == S_ON) || (r_state == S_BYZERO);
    assign byzero_o = ready_o & r_byzero;
`else
    assign busy_o   = (r_state == S_ON);
`endif

endmodule

`default_nettype wire

// File: tb/tb_div_unit.sv
// ============================================================================
// Module   : tb_div_unit
// Purpose  : Directed self-checking bench for div_unit with a result scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_div_unit;

    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst;
    logic           start_i;
    logic           annul_i;
    logic           signed_i;
    logic [W-1:0]   opdata1_i;
    logic [W-1:0]   opdata2_i;
    logic [2*W-1:0] result_o;
    logic           ready_o;
    logic           busy_o;
`ifdef DIV_BYZERO_EN
    logic           byzero_o;
`endif

    int             n_tests = 0;
    int             n_fail  = 0;
    logic [2*W-1:0] sb_q[$];

    div_unit #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start_i   (start_i),
        .annul_i   (annul_i),
        .signed_i  (signed_i),
        .opdata1_i (opdata1_i),
        .opdata2_i (opdata2_i),
        .result_o  (result_o),
        .ready_o   (ready_o),
        .busy_o    (busy_o)
`ifdef DIV_BYZERO_EN
       ,.byzero_o  (byzero_o)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference arithmetic: {remainder, quotient}
    function automatic logic [2*W-1:0] model(input logic s, input logic [W-1:0] x, input logic [W-1:0] y);
        int sx, sy, q, r;
        if (y == '0) return {x, {W{1'b1}}};
        if (!s) return {x % y, x / y};
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        sx = x;
        sy = y;
        q  = sx / sy;
        r  = sx % sy;
        return {r, q};
    endfunction

    task automatic do_div(input string tag, input logic s, input logic [W-1:0] x,
                          input logic [W-1:0] y, input logic [2*W-1:0] exp, input int exp_edges);
        int             edges;
        logic           busy_ok;
        logic [2*W-1:0] want;
        sb_q.push_back(exp);
        signed_i  = s;
        opdata1_i = x;
        opdata2_i = y;
        start_i   = 1'b1;
        tick;
        edges   = 0;
        busy_ok = 1'b1;
        while (!ready_o && edges < 50) begin
            if (!busy_o) busy_ok = 1'b0;
            tick;
            edges++;
        end
        check({tag, " latency"}, 64'(edges), 64'(exp_edges));
        check({tag, " busy"}, {63'h0, busy_ok}, 64'h1);
        check({tag, " busy at ready"}, {63'h0, busy_o}, 64'h0);
        want = '0;
        if (sb_q.size() > 0) want = sb_q.pop_front();
        check({tag, " result"}, result_o, want);
        repeat (3) tick;
        check({tag, " hold"}, {ready_o, result_o[62:0]}, {1'b1, want[62:0]});
        start_i = 1'b0;
        tick;
        check({tag, " release"}, {63'h0, ready_o}, 64'h0);
        check({tag, " result cleared"}, result_o, 64'h0);
    endtask

    initial begin
        int             quiet;
        logic [W-1:0]   rx;
        logic [W-1:0]   ry;
        logic           rs;

        rst       = 1'b1;
        start_i   = 1'b1;
        annul_i   = 1'b0;
        signed_i  = 1'b0;
        opdata1_i = 32'd100;
        opdata2_i = 32'd7;
        repeat (2) tick;
        check("reset outputs", {61'h0, ready_o, busy_o, |result_o}, 64'h0);
        rst     = 1'b0;
        start_i = 1'b0;
        tick;
        check("idle after reset", {62'h0, ready_o, busy_o}, 64'h0);

        do_div("divu 100/7", 1'b0, 32'd100, 32'd7, {32'h2, 32'hE}, W);
        do_div("div -7/2", 1'b1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, W);
        do_div("div 7/-2", 1'b1, 32'd7, 32'hFFFF_FFFE, {32'h1, 32'hFFFF_FFFD}, W);
        do_div("div min/-1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000}, W);
        do_div("divu max/1", 1'b0, 32'hFFFF_FFFF, 32'd1, {32'h0, 32'hFFFF_FFFF}, W);
        do_div("divu big", 1'b0, 32'hF000_0000, 32'h8000_0001, {32'h6FFF_FFFF, 32'h1}, W);

        for (int i = 0; i < 4; i++) begin
            rs = i[0];
            rx = $urandom;
            ry = $urandom_range(1, 32'h0000_FFFF);
            if (i == 3) ry = ~ry;
            do_div("random", rs, rx, ry, model(rs, rx, ry), W);
        end

        // Flush mid-iteration: the aborted op must never report a result
        signed_i  = 1'b0;
        opdata1_i = 32'd1000;
        opdata2_i = 32'd3;
        start_i   = 1'b1;
        tick;
        repeat (10) tick;
        annul_i = 1'b1;
        tick;
        check("annul idle", {62'h0, ready_o, busy_o}, 64'h0);
        annul_i = 1'b0;
        start_i = 1'b0;
        quiet   = 1;
        repeat (40) begin
            tick;
            if (ready_o || busy_o) quiet = 0;
        end
        check("annul no ready", 64'(quiet), 64'h1);
        do_div("after annul", 1'b0, 32'd1000, 32'd3, model(1'b0, 32'd1000, 32'd3), W);

        // Reset mid-iteration with start held: only a fresh full run completes
        signed_i  = 1'b1;
        opdata1_i = 32'hFFFF_FF9C;
        opdata2_i = 32'd7;
        start_i   = 1'b1;
        tick;
        repeat (20) tick;
        rst = 1'b1;
        tick;
        check("mid reset outputs", {61'h0, ready_o, busy_o, |result_o}, 64'h0);
`ifdef DIV_BYZERO_EN
        check("mid reset byzero", {63'h0, byzero_o}, 64'h0);
`endif
        rst = 1'b0;
        do_div("after reset", 1'b1, 32'hFFFF_FF9C, 32'd7, {32'hFFFF_FFFE, 32'hFFFF_FFF2}, W);

`ifdef DIV_BYZERO_EN
        do_div("divu by zero", 1'b0, 32'h1234_5678, 32'h0, 64'h0, 1);
        signed_i  = 1'b0;
        opdata1_i = 32'h1234_5678;
        opdata2_i = 32'h0;
        start_i   = 1'b1;
        repeat (2) tick;
        check("byzero flag", {63'h0, byzero_o}, 64'h1);
        start_i = 1'b0;
        tick;
        check("byzero cleared", {63'h0, byzero_o}, 64'h0);
`else
        do_div("divu by zero", 1'b0, 32'h1234_5678, 32'h0, {32'h1234_5678, 32'hFFFF_FFFF}, W);
`endif

        check("scoreboard drained", 64'(sb_q.size()), 64'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 SHALL have parameter: WIDTH, 32, operand width in bits.
REQ-002 SHALL have port clk, input, 1, rising-edge clock.
REQ-003 SHALL have port rst, input, 1, reset: synchronous, active-high.
REQ-004 SHALL have port start_i, input, 1, division request from the EX stage; held high until result consumed.
REQ-005 SHALL have port annul_i, input, 1, pipeline flush; cancels any operation.
REQ-006 SHALL have port signed_i, input, 1: 1 = DIV (two's complement), 0 = DIVU.
REQ-007 SHALL have port opdata1_i, input, WIDTH, dividend.
REQ-008 SHALL have port opdata2_i, input, WIDTH, divisor.
REQ-009 SHALL have port result_o, output, 2*WIDTH, {remainder (HI), quotient (LO)}.
REQ-010 SHALL have port ready_o, output, 1, result valid.
REQ-011 SHALL have port busy_o, output, 1, iteration in progress; EX uses it to stall.
REQ-012 SHALL have port byzero_o, output, 1, divide-by-zero flag; present only with DIV_BYZERO_EN.

Function
REQ-013 SHALL implement FSM states IDLE, BYZERO, ON, END; BYZERO exists only with DIV_BYZERO_EN.
REQ-014 IDLE: start_i=1 and annul_i=0 at an edge SHALL latch operands and signed_i, clear iteration counter, go to ON (or BYZERO, REQ-024); otherwise stay IDLE.
REQ-015 Operand capture: when signed_i=1, SHALL latch absolute values of negative operands; latched sign bits drive final correction.
REQ-016 ON: each edge SHALL perform one restoring step (shift partial remainder left, bring in next dividend MSB, subtract divisor if remainder >= divisor, shift 1/0 into quotient); counter +1.
REQ-017 ON: edge with counter = WIDTH-1 SHALL complete the final step, apply sign correction, register result, go to END.
REQ-018 Latency: with start sampled at edge 0, iterations occur at edges 1..WIDTH; ready_o SHALL be high in the cycle after edge WIDTH (32 for default).
REQ-019 Sign correction: quotient negated when dividend and divisor signs differ; remainder negated when dividend negative; none for signed_i=0.
REQ-020 Signed 0x80000000 / 0xFFFFFFFF SHALL give quotient 0x80000000, remainder 0.
REQ-021 END: result_o and ready_o=1 SHALL hold while start_i=1; start_i=0 SHALL go to IDLE at next edge.
REQ-022 annul_i=1 in any state SHALL go to IDLE at next edge, priority over start_i; no ready_o pulse follows.
REQ-023 start_i=0 while in ON SHALL abort to IDLE at next edge.
REQ-024 busy_o SHALL be 1 in ON and BYZERO, else 0; ready_o 1 only in END; result_o SHALL be 0 outside END.

Reset
REQ-025 rst=1 at an edge SHALL force IDLE, counter 0, result_o=0, ready_o=0, busy_o=0, byzero_o=0, regardless of other inputs, including mid-operation.

Configuration
REQ-026 Macro DIV_BYZERO_EN defined: opdata2_i=0 accepted in IDLE SHALL go to BYZERO for one cycle, then END with result_o=0 and byzero_o=1; ready_o rises after 2 edges.
REQ-027 DIV_BYZERO_EN undefined: no BYZERO state, no byzero_o port; divisor 0 SHALL run full WIDTH iterations (unsigned: quotient 0xFFFFFFFF, remainder = dividend).

Verification
REQ-028 DIVU 100/7, start held -> ready_o after edge 32, result_o = {0x00000002, 0x0000000E}, busy_o high edges 1..32.
REQ-029 DIV -7/2 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF; DIV 7/-2 -> quotient 0xFFFFFFFD, remainder 0x00000001.
REQ-030 DIV 0x80000000/0xFFFFFFFF -> {0x00000000, 0x80000000}.
REQ-031 annul_i pulsed at iteration 10 -> IDLE next edge, ready_o never asserts; new start then completes normally.
REQ-032 rst at iteration 20 -> all outputs 0 next cycle; start held through rst yields no ready_o until a fresh 32-edge run.
REQ-033 Divisor 0, dividend 0x12345678, DIVU: with macro -> ready_o after 2 edges, result 0, byzero_o=1; without -> after 32 edges, {0x12345678, 0xFFFFFFFF}.
